// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types, mode constants and operand extension for booth_mult_seq
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;
  localparam int   MAX_WIDTH     = 64;

  // Widen a width-bit operand by filling every bit at or above position width
  // with its sign (signed mode) or zero (unsigned mode); caller truncates.
  function automatic logic [MAX_WIDTH:0] ext(input logic [MAX_WIDTH-1:0] operand,
                                             input int width,
                                             input logic mode);
    logic [MAX_WIDTH:0] padded;
    logic               fill;
    padded = {1'b0, operand};
    fill   = (mode == MODE_SIGNED) ? padded[width-1] : 1'b0;
    for (int i = 0; i <= MAX_WIDTH; i++) begin
      if (i >= width) padded[i] = fill;
    end
    return padded;
  endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth step: add/sub/none then arithmetic shift
module booth_step #(
  parameter int W = 33
) (
  input  logic [W-1:0] p_hi,
  input  logic [W-1:0] p_lo,
  input  logic         q_m1,
  input  logic [W-1:0] m,
  output logic [W-1:0] nxt_p_hi,
  output logic [W-1:0] nxt_p_lo,
  output logic         nxt_q_m1
);

  logic [W-1:0] sum;

  // W-bit wrap is intentional: the operands are one bit wider than the data,
  // so the Booth partial sums always fit.
  always_comb begin
    sum = p_hi;
    case ({p_lo[0], q_m1})
      2'b01:   sum = p_hi + m;
      2'b10:   sum = p_hi - m;
      default: sum = p_hi;
    endcase
  end

  assign nxt_p_hi = {sum[W-1], sum[W-1:1]};
  assign nxt_p_lo = {sum[0], p_lo[W-1:1]};
  assign nxt_q_m1 = p_lo[0];

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - iterative radix-2 Booth multiplier with valid/ready handshakes
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               signed_mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int W1    = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [W1-1:0]    m;
  logic [W1-1:0]    p_hi;
  logic [W1-1:0]    p_lo;
  logic             q_m1;

  logic [W1-1:0]    a_ext;
  logic [W1-1:0]    b_ext;
  logic [W1-1:0]    nxt_p_hi;
  logic [W1-1:0]    nxt_p_lo;
  logic             nxt_q_m1;

  assign a_ext = W1'(ext(MAX_WIDTH'(A), WIDTH, signed_mode));
  assign b_ext = W1'(ext(MAX_WIDTH'(B), WIDTH, signed_mode));

  booth_step #(
    .W (W1)
  ) u_step (
    .p_hi     (p_hi),
    .p_lo     (p_lo),
    .q_m1     (q_m1),
    .m        (m),
    .nxt_p_hi (nxt_p_hi),
    .nxt_p_lo (nxt_p_lo),
    .nxt_q_m1 (nxt_q_m1)
  );

  // in_ready is registered and only re-armed from IDLE or the output
  // handshake, so it stays low while reset is held and there is no skid slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      count     <= '0;
      m         <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      q_m1      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            m        <= a_ext;
            p_lo     <= b_ext;
            p_hi     <= '0;
            q_m1     <= 1'b0;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CALC: begin
          p_hi  <= nxt_p_hi;
          p_lo  <= nxt_p_lo;
          q_m1  <= nxt_q_m1;
          count <= count + 1'b1;
          // Final step: take the low 2*WIDTH bits of the just-computed product.
          if (count == LAST_STEP) begin
            result    <= {nxt_p_hi[WIDTH-2:0], nxt_p_lo};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - self-checking bench for booth_mult_seq at WIDTH=32 and WIDTH=8
module tb_booth_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [31:0] a32, b32;
  logic        mode32, iv32, ir32, ov32, ordy32, busy32;
  logic [63:0] res32;

  logic [7:0]  a8, b8;
  logic        mode8, iv8, ir8, ov8, ordy8, busy8;
  logic [15:0] res8;

  int checks = 0;
  int errors = 0;

  booth_mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .A(a32), .B(b32), .signed_mode(mode32),
    .in_valid(iv32), .in_ready(ir32), .result(res32), .out_valid(ov32),
    .out_ready(ordy32), .busy(busy32)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .A(a8), .B(b8), .signed_mode(mode8),
    .in_valid(iv8), .in_ready(ir8), .result(res8), .out_valid(ov8),
    .out_ready(ordy8), .busy(busy8)
  );

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic m);
    if (m) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return 64'(a) * 64'(b);
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic m);
    if (m) return 16'(int'($signed(a)) * int'($signed(b)));
    return 16'(int'(a) * int'(b));
  endfunction

  // Drive one operation into dut32; returns result, cycles from accept to out_valid,
  // and cycles waited for in_ready. Completes the output handshake if out_ready is high.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic m,
                       output logic [63:0] r, output int lat, output int w);
    w = 0;
    while (!ir32 && w < 200) begin @(posedge clk); #1; w++; end
    if (!ir32) begin
      checks++; errors++;
      $display("FAIL run32_in_ready: in_ready=%0b after %0d cycles, required 1", ir32, w);
    end
    a32 = a; b32 = b; mode32 = m; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    a32 = $urandom; b32 = $urandom; mode32 = 1'($urandom);
    lat = 0;
    while (!ov32 && lat < 200) begin @(posedge clk); #1; lat++; end
    r = res32;
    if (ordy32) begin @(posedge clk); #1; end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic m,
                      output logic [15:0] r, output int lat);
    int w = 0;
    while (!ir8 && w < 200) begin @(posedge clk); #1; w++; end
    if (!ir8) begin
      checks++; errors++;
      $display("FAIL run8_in_ready: in_ready=%0b after %0d cycles, required 1", ir8, w);
    end
    a8 = a; b8 = b; mode8 = m; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    lat = 0;
    while (!ov8 && lat < 200) begin @(posedge clk); #1; lat++; end
    r = res8;
    if (ordy8) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a32 = 32'd1234; b32 = 32'd5678; mode32 = 1'b1; iv32 = 1'b1; ordy32 = 1'b1;
    a8 = 8'd12; b8 = 8'd34; mode8 = 1'b1; iv8 = 1'b1; ordy8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ir32 !== 1'b0 || ov32 !== 1'b0 || busy32 !== 1'b0 || res32 !== 64'd0) begin
      errors++;
      $display("FAIL reset_state32: in_ready=%0b out_valid=%0b busy=%0b result=%h, required 0 0 0 0",
               ir32, ov32, busy32, res32);
    end
    checks++;
    if (ir8 !== 1'b0 || ov8 !== 1'b0 || busy8 !== 1'b0 || res8 !== 16'd0) begin
      errors++;
      $display("FAIL reset_state8: in_ready=%0b out_valid=%0b busy=%0b result=%h, required 0 0 0 0",
               ir8, ov8, busy8, res8);
    end
    iv32 = 1'b0; iv8 = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ir32 !== 1'b1 || busy32 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b busy=%0b, required 1 0", ir32, busy32);
    end
  endtask

  task automatic test_directed();
    int sa[5] = '{50, -80, -999, 98765, 98756};
    int sb[5] = '{-40, -65, 999, 1, 0};
    logic [63:0] r;
    int lat, w;
    for (int i = 0; i < 5; i++) begin
      run32(32'(sa[i]), 32'(sb[i]), 1'b1, r, lat, w);
      checks++;
      if (r !== ref32(32'(sa[i]), 32'(sb[i]), 1'b1)) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h, required %h", i, r, ref32(32'(sa[i]), 32'(sb[i]), 1'b1));
      end
      checks++;
      if (lat !== 33) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d, required 33", i, lat);
      end
      if (i == 0) begin
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_F830) begin
          errors++;
          $display("FAIL directed_first_const: got %h, required ffffffffffff f830", r);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    int lat, w;
    run32(32'd7, 32'd6, 1'b0, r, lat, w);
    for (int i = 0; i < 3; i++) begin
      run32(32'(i + 3), 32'(-i - 5), 1'b1, r, lat, w);
      checks++;
      if (w !== 0 || r !== ref32(32'(i + 3), 32'(-i - 5), 1'b1)) begin
        errors++;
        $display("FAIL back_to_back[%0d]: wait=%0d result=%h, required wait 0 result %h",
                 i, w, r, ref32(32'(i + 3), 32'(-i - 5), 1'b1));
      end
    end
  endtask

  task automatic test_max_operands();
    logic [63:0] r;
    int lat, w;
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat, w);
    checks++;
    if (r !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL max_unsigned: got %h, required fffffffe00000001", r);
    end
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, r, lat, w);
    checks++;
    if (r !== 64'd1) begin
      errors++;
      $display("FAIL max_signed: got %h, required 1", r);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    int lat;
    bit stable = 1'b1;
    ordy32 = 1'b0;
    a32 = 32'd1000; b32 = 32'hFFFF_FF00; mode32 = 1'b1; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 200) begin @(posedge clk); #1; lat++; end
    held = res32;
    checks++;
    if (held !== ref32(32'd1000, 32'hFFFF_FF00, 1'b1) || lat !== 33) begin
      errors++;
      $display("FAIL bp_first: result=%h latency=%0d, required %h 33",
               held, lat, ref32(32'd1000, 32'hFFFF_FF00, 1'b1));
    end
    a32 = 32'd7; b32 = 32'd9; mode32 = 1'b1; iv32 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov32 !== 1'b1 || res32 !== held || ir32 !== 1'b0 || busy32 !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_stall: out_valid=%0b in_ready=%0b result=%h, required 1 0 %h", ov32, ir32, res32, held);
    end
    ordy32 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b, required 0 1", ov32, ir32);
    end
    @(posedge clk); #1;
    iv32 = 1'b0;
    checks++;
    if (busy32 !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_accept: busy=%0b, required 1", busy32);
    end
    lat = 0;
    while (!ov32 && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++;
    if (res32 !== 64'd63 || lat !== 33) begin
      errors++;
      $display("FAIL bp_second: result=%h latency=%0d, required 3f 33", res32, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc();
    bit spurious = 1'b0;
    a32 = 32'd11; b32 = 32'd13; mode32 = 1'b0; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov32 !== 1'b0 || res32 !== 64'd0 || busy32 !== 1'b0 || ir32 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%0b result=%h busy=%0b in_ready=%0b, required 0 0 0 0",
               ov32, res32, busy32, ir32);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ir32 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: in_ready=%0b, required 1", ir32);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov32 !== 1'b0 || busy32 !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL mid_reset_quiet: spurious out_valid/busy seen, required none");
    end
  endtask

  task automatic test_width8();
    logic [15:0] r;
    int lat;
    run8(8'h80, 8'h80, 1'b1, r, lat);
    checks++;
    if (r !== 16'h4000 || lat !== 9) begin
      errors++;
      $display("FAIL w8_signed_min: result=%h latency=%0d, required 4000 9", r, lat);
    end
    run8(8'hFF, 8'hFF, 1'b0, r, lat);
    checks++;
    if (r !== 16'hFE01 || lat !== 9) begin
      errors++;
      $display("FAIL w8_unsigned_max: result=%h latency=%0d, required fe01 9", r, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] r8;
    logic [63:0] r32;
    logic [7:0]  x8, y8;
    logic [31:0] x32, y32;
    logic        m;
    int lat, w;
    for (int i = 0; i < 1000; i++) begin
      x8 = 8'($urandom); y8 = 8'($urandom); m = 1'($urandom);
      if ($urandom_range(0, 7) == 0) x8 = 8'h80;
      if ($urandom_range(0, 7) == 0) y8 = 8'h00;
      run8(x8, y8, m, r8, lat);
      checks++;
      if (r8 !== ref8(x8, y8, m) || lat !== 9) begin
        errors++;
        $display("FAIL rand8[%0d]: a=%h b=%h mode=%0b result=%h latency=%0d, required %h 9",
                 i, x8, y8, m, r8, lat, ref8(x8, y8, m));
      end
    end
    for (int i = 0; i < 200; i++) begin
      x32 = $urandom; y32 = $urandom; m = 1'($urandom);
      if ($urandom_range(0, 7) == 0) x32 = 32'h8000_0000;
      run32(x32, y32, m, r32, lat, w);
      checks++;
      if (r32 !== ref32(x32, y32, m) || lat !== 33) begin
        errors++;
        $display("FAIL rand32[%0d]: a=%h b=%h mode=%0b result=%h latency=%0d, required %h 33",
                 i, x32, y32, m, r32, lat, ref32(x32, y32, m));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_max_operands();
    test_backpressure();
    test_reset_mid_calc();
    test_width8();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised iterative radix-2 Booth multiplier. Successor to the single-cycle registered 32x32 signed multiplier.
Adds configurable operand width, per-operation signed/unsigned mode, and valid/ready handshakes on input and output.
Trades latency for area: one Booth step per clock. Sits between the operand source (ALU/datapath) and the result consumer.

Parameters:
WIDTH, 32, operand width in bits; legal range 2..64; result is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+2), step-counter width; derived localparam, not overridable.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
A  input  WIDTH  multiplicand; sampled on input handshake
B  input  WIDTH  multiplier; sampled on input handshake
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled on input handshake
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
result  output  2*WIDTH  product; stable while out_valid=1
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
busy  output  1  high in CALC or DONE

Behaviour:
- Internals:
  - Operands extended to WIDTH+1 bits: sign-extend when signed_mode=1, zero-extend when 0.
  - Accumulator {P_hi[WIDTH:0], P_lo[WIDTH:0], q_-1}.
  - Exactly WIDTH+1 Booth steps per operation. result = low 2*WIDTH bits of the (2*WIDTH+2)-bit product.
  - This is exact for both modes; no overflow is possible.
- Booth step on {q0, q_-1}:
  - 01: P_hi += M.
  - 10: P_hi -= M.
  - 00/11: no change.
  - Then arithmetic right shift of the whole accumulator by 1.
  - Add/sub is WIDTH+1 bits; wrap is intended.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready at edge E0: latch M=ext(A), load P_lo=ext(B), clear P_hi and q_-1, count=0 -> CALC.
  - CALC: in_ready=0. One step per cycle, count++. At the edge where count==WIDTH (the step WIDTH+1 completes): register result -> DONE.
  - DONE: out_valid=1, in_ready=0, result held. On out_valid & out_ready -> IDLE.
  - No skid buffer: the next operation is accepted no earlier than the cycle after the output handshake.
- Latency:
  - Input accepted at edge E0; out_valid rises after edge E0+WIDTH+1 (WIDTH+1 cycles in CALC).
  - Minimum issue interval WIDTH+3 cycles with out_ready tied high.
- in_valid while not in IDLE: ignored, no effect; the source must hold it.
- A/B/signed_mode changes during CALC/DONE: no effect on the operation in flight.
- out_ready low in DONE: stall indefinitely; result and out_valid stable.
- Reset:
  - Reset values: state=IDLE, result=0, out_valid=0, busy=0, counter=0, accumulator=0.
  - in_ready=0 while reset is high; in_ready=1 the first cycle after reset is released.
  - Reset mid-CALC or in DONE aborts the operation. No stale result is ever presented.
- Simultaneous reset and in_valid: reset wins; operands are not captured.
- Zero operands take the same WIDTH+1 steps; there is no early termination, so latency is fixed and deterministic.

Decomposition:
- Package mult_pkg:
  - state enum {IDLE, CALC, DONE}.
  - MODE_UNSIGNED=0, MODE_SIGNED=1 constants.
  - Helper function ext(operand, mode).
- Sub-module booth_step: combinational, parameter W=WIDTH+1.
  - Inputs: P_hi, P_lo, q_m1, M.
  - Outputs: next P_hi, P_lo, q_m1 (add/sub/none plus arithmetic shift).
- Top module holds the FSM, counter, operand/accumulator registers and the result register.

Test Plan:
- WIDTH=32, signed, A=50, B=-40, out_ready=1 -> out_valid exactly 33 cycles after accept; result=64'hFFFF_FFFF_FFFF_F830 (-2000).
- Signed pairs (-80,-65)->5200; (-999,999)->-998001; (98765,1)->98765; (98756,0)->0. Each one back-to-back as soon as in_ready rises, and each latency =33.
- Unsigned, A=B=32'hFFFF_FFFF -> 64'hFFFF_FFFE_0000_0001. Same operands signed -> 64'd1.
- Backpressure: out_ready=0 for 10 cycles in DONE -> result/out_valid stable, in_ready=0, a second in_valid is ignored. out_ready=1 -> IDLE next cycle, then the second operation is accepted.
- Reset asserted 5 cycles into CALC -> next cycle out_valid=0, result=0, busy=0. in_ready=1 after release; no spurious out_valid for 40 cycles.
- WIDTH=8 build, signed: (-128,-128) -> 16'h4000, latency 9; unsigned (255,255) -> 16'hFE01. Random 1000-vector signed/unsigned compare against a behavioural reference.
